// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: merges pipe WB and long-latency unit
// results, tracks LU destinations in a busy scoreboard, and bounds LU starvation.
module rf_wb_scheduler #(
    parameter int XLEN       = 64,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 4,
    parameter int AW         = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   dec_rs1_i,
    input  logic [AW-1:0]   dec_rs2_i,
    input  logic [AW-1:0]   dec_rd_i,
    input  logic            dec_valid_i,
    output logic            dec_stall_o,
    input  logic            lu_issue_i,
    input  logic [AW-1:0]   lu_issue_rd_i,
    input  logic            lu_valid_i,
    input  logic [AW-1:0]   lu_rd_i,
    input  logic [XLEN-1:0] lu_data_i,
    input  logic [XLEN-1:0] lu_pc_i,
    output logic            lu_ready_o,
    input  logic            pipe_wb_en_i,
    input  logic [AW-1:0]   pipe_wb_rd_i,
    input  logic [XLEN-1:0] pipe_wb_data_i,
    input  logic [XLEN-1:0] pipe_wb_pc_i,
    output logic            wb_hold_o,
    output logic            rf_wr_en_o,
    output logic [AW-1:0]   rf_wr_addr_o,
    output logic [XLEN-1:0] rf_wr_data_o,
    output logic [XLEN-1:0] commit_pc_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            hold_q, hold_d;
    logic            pipe_req;
    logic            lu_refused;

    assign wb_hold_o  = hold_q;
    assign pipe_req   = pipe_wb_en_i & ~hold_q;
    assign lu_ready_o = lu_valid_i & ~pipe_req;
    assign lu_refused = lu_valid_i & ~lu_ready_o;

    always_comb begin
        rf_wr_en_o   = 1'b0;
        rf_wr_addr_o = '0;
        rf_wr_data_o = '0;
        commit_pc_o  = '0;
        if (pipe_req) begin
            rf_wr_en_o   = 1'b1;
            rf_wr_addr_o = pipe_wb_rd_i;
            rf_wr_data_o = pipe_wb_data_i;
            commit_pc_o  = pipe_wb_pc_i;
        end else if (lu_valid_i) begin
            rf_wr_en_o   = 1'b1;
            rf_wr_addr_o = lu_rd_i;
            rf_wr_data_o = lu_data_i;
            commit_pc_o  = lu_pc_i;
        end
    end

    always_comb begin
        dec_stall_o = 1'b0;
        if (dec_valid_i) begin
            dec_stall_o = ((dec_rs1_i != '0) & busy_q[dec_rs1_i])
                        | ((dec_rs2_i != '0) & busy_q[dec_rs2_i])
                        | ((dec_rd_i  != '0) & busy_q[dec_rd_i]);
        end
    end

    // Clear before set so a same-edge retire/issue of one rd leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (lu_ready_o) begin
            busy_d[lu_rd_i] = 1'b0;
        end
        if (lu_issue_i && (lu_issue_rd_i != '0)) begin
            busy_d[lu_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = '0;
        hold_d   = 1'b0;
        if (lu_refused) begin
            starve_d = starve_q + 1'b1;
            hold_d   = (starve_q == STARVE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: per-cycle comparison against a
// behavioural model plus literal checks on the key scenario cycles.
module tb_rf_wb_scheduler;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int SMAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_valid;
    logic            dec_stall;
    logic            lu_issue;
    logic [4:0]      lu_issue_rd;
    logic            lu_valid;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data, lu_pc;
    logic            lu_ready;
    logic            pipe_en;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data, pipe_pc;
    logic            wb_hold;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] commit_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd),
        .dec_valid_i(dec_valid), .dec_stall_o(dec_stall),
        .lu_issue_i(lu_issue), .lu_issue_rd_i(lu_issue_rd),
        .lu_valid_i(lu_valid), .lu_rd_i(lu_rd),
        .lu_data_i(lu_data), .lu_pc_i(lu_pc), .lu_ready_o(lu_ready),
        .pipe_wb_en_i(pipe_en), .pipe_wb_rd_i(pipe_rd),
        .pipe_wb_data_i(pipe_data), .pipe_wb_pc_i(pipe_pc),
        .wb_hold_o(wb_hold), .rf_wr_en_o(wr_en), .rf_wr_addr_o(wr_addr),
        .rf_wr_data_o(wr_data), .commit_pc_o(commit_pc)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: set of busy registers, run length of refused LU cycles, hold flag.
    bit m_busy [NREG];
    int m_refused_run;
    bit m_hold;
    bit m_live = 0;

    function automatic bit m_pipe_wins();
        return pipe_en && !m_hold;
    endfunction

    function automatic bit m_lu_accepted();
        return lu_valid && !m_pipe_wins();
    endfunction

    function automatic bit m_dep(input logic [4:0] a);
        return (a != 0) && m_busy[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_refused_run = 0;
            m_hold = 0;
            m_live = 1;
        end else if (m_live) begin
            bit acc, refused;
            acc = m_lu_accepted();
            refused = lu_valid && !acc;
            if (acc) m_busy[lu_rd] = 0;
            if (lu_issue && lu_issue_rd != 0) m_busy[lu_issue_rd] = 1;
            m_hold = refused && (m_refused_run == SMAX - 1);
            m_refused_run = refused ? m_refused_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (m_live && !rst) begin
            logic [4:0]      ea;
            logic [XLEN-1:0] ed, ep;
            bit              ew;
            ew = 0; ea = 0; ed = 0; ep = 0;
            if (m_pipe_wins()) begin
                ew = 1; ea = pipe_rd; ed = pipe_data; ep = pipe_pc;
            end else if (lu_valid) begin
                ew = 1; ea = lu_rd; ed = lu_data; ep = lu_pc;
            end
            chk("m_wr_en", 64'(wr_en), 64'(ew));
            chk("m_wr_addr", 64'(wr_addr), 64'(ea));
            chk("m_wr_data", wr_data, ed);
            chk("m_commit_pc", commit_pc, ep);
            chk("m_lu_ready", 64'(lu_ready), 64'(m_lu_accepted()));
            chk("m_wb_hold", 64'(wb_hold), 64'(m_hold));
            chk("m_stall", 64'(dec_stall), 64'(dec_valid &&
                (m_dep(dec_rs1) || m_dep(dec_rs2) || m_dep(dec_rd))));
        end
    end

    task automatic idle();
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_valid = 0;
        lu_issue = 0; lu_issue_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0; lu_pc = 0;
        pipe_en = 0; pipe_rd = 0; pipe_data = 0; pipe_pc = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        mid();
        chk("t1_wr_en", 64'(wr_en), 64'd0);
        chk("t1_stall", 64'(dec_stall), 64'd0);
        chk("t1_hold", 64'(wb_hold), 64'd0);
        chk("t1_pc", commit_pc, 64'd0);

        // LU issue rd=5, decode reads x5
        cyc();
        lu_issue = 1; lu_issue_rd = 5;
        dec_valid = 1; dec_rs1 = 5;
        mid();
        chk("t2_stall_c0", 64'(dec_stall), 64'd0);
        cyc();
        lu_issue = 0;
        mid();
        chk("t2_stall_c1", 64'(dec_stall), 64'd1);
        cyc();
        lu_valid = 1; lu_rd = 5; lu_data = 64'hAB; lu_pc = 64'h1000;
        mid();
        chk("t2_wr_addr", 64'(wr_addr), 64'd5);
        chk("t2_wr_data", wr_data, 64'hAB);
        chk("t2_pc", commit_pc, 64'h1000);
        chk("t2_stall_ret", 64'(dec_stall), 64'd1);
        cyc();
        lu_valid = 0;
        mid();
        chk("t2_stall_after", 64'(dec_stall), 64'd0);

        // Pipe and LU collide
        cyc();
        idle();
        pipe_en = 1; pipe_rd = 3; pipe_data = 64'h33; pipe_pc = 64'h2000;
        lu_valid = 1; lu_rd = 7; lu_data = 64'h77; lu_pc = 64'h3000;
        mid();
        chk("t3_addr_pipe", 64'(wr_addr), 64'd3);
        chk("t3_ready0", 64'(lu_ready), 64'd0);
        cyc();
        pipe_en = 0;
        mid();
        chk("t3_addr_lu", 64'(wr_addr), 64'd7);
        chk("t3_data_lu", wr_data, 64'h77);
        chk("t3_ready1", 64'(lu_ready), 64'd1);

        // Starvation: pipe writes every cycle, LU waits
        cyc();
        lu_rd = 11; lu_data = 64'hBB; lu_pc = 64'h4000;
        for (int k = 1; k <= 4; k++) begin
            pipe_en = 1; pipe_rd = 12; pipe_data = 64'hC0 + 64'(k);
            pipe_pc = 64'h5000 + 64'(k);
            mid();
            chk("t4_hold_low", 64'(wb_hold), 64'd0);
            chk("t4_pipe_data", wr_data, 64'hC0 + 64'(k));
            cyc();
        end
        pipe_data = 64'hC5; pipe_pc = 64'h5005;
        mid();
        chk("t4_hold_c5", 64'(wb_hold), 64'd1);
        chk("t4_lu_addr", 64'(wr_addr), 64'd11);
        chk("t4_lu_data", wr_data, 64'hBB);
        cyc();
        lu_valid = 0;
        mid();
        chk("t4_hold_c6", 64'(wb_hold), 64'd0);
        chk("t4_held_addr", 64'(wr_addr), 64'd12);
        chk("t4_held_data", wr_data, 64'hC5);
        cyc();
        idle();

        // rd=0 never becomes busy
        lu_issue = 1; lu_issue_rd = 0; dec_valid = 1; dec_rs1 = 0;
        cyc();
        lu_issue = 0;
        mid();
        chk("t5_x0_stall", 64'(dec_stall), 64'd0);
        cyc();
        dec_valid = 0;
        lu_issue = 1; lu_issue_rd = 9;
        cyc();
        lu_issue = 0;
        dec_valid = 1; dec_rs2 = 9;
        mid();
        chk("t5_x9_busy", 64'(dec_stall), 64'd1);
        cyc();
        dec_valid = 0;
        lu_valid = 1; lu_rd = 9; lu_data = 64'h99; lu_pc = 64'h6000;
        lu_issue = 1; lu_issue_rd = 9;
        cyc();
        idle();
        dec_valid = 1; dec_rs2 = 9;
        mid();
        chk("t5_set_wins", 64'(dec_stall), 64'd1);

        // Reset mid-operation
        cyc();
        idle();
        lu_issue = 1; lu_issue_rd = 4;
        cyc();
        lu_issue = 0;
        pipe_en = 1; pipe_rd = 1; pipe_data = 64'h11;
        lu_valid = 1; lu_rd = 13; lu_data = 64'hDD;
        cyc(); cyc();
        idle();
        rst = 1;
        cyc();
        rst = 0;
        dec_valid = 1; dec_rs1 = 4;
        mid();
        chk("t6_stall", 64'(dec_stall), 64'd0);
        chk("t6_hold", 64'(wb_hold), 64'd0);
        cyc();
        dec_valid = 0;
        pipe_en = 1; pipe_rd = 2; pipe_data = 64'h22;
        lu_valid = 1; lu_rd = 14; lu_data = 64'hEE;
        cyc(); cyc(); cyc();
        mid();
        chk("t6_cnt_cleared", 64'(wb_hold), 64'd0);
        cyc();
        mid();
        chk("t6_hold_fresh", 64'(wb_hold), 64'd1);
        cyc();
        idle();
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
